// File: rtl/instruction_fetch_queue.sv
// instruction_fetch_queue
//
// DEPTH-entry prefetch queue between instruction memory and decode.
// Sequential requests are issued ahead of decode. Each returned instruction
// is tagged with the PC it was fetched from. A redirect flushes the queue.
// If a request is still outstanding when a redirect arrives, that response
// is waited out and discarded before fetching from the new target.
//
// Optional feature macro: FETCH_QUEUE_BYPASS_EN
//   When defined, a response that arrives while the queue is empty is
//   presented to decode in the same cycle.
//   When undefined, decode outputs come from queue registers only.
//
// Ports
//   f_clk         clock, rising edge
//   f_rst         synchronous active-high reset
//   o_syn         memory request valid
//   o_addr_instr  request address (low A_WIDTH bits of the fetch PC)
//   i_ack         memory response strobe, completes the pending request
//   i_instr       response data, valid with i_ack
//   change_pc     redirect / flush
//   alu_pc_value  redirect target
//   i_stall       decode not accepting
//   o_ce          head entry valid to decode
//   o_instr       head instruction (0 when o_ce=0)
//   pc            PC of head instruction (0 when o_ce=0)
//   o_count       queue occupancy
//
// FSM states
//   state  | meaning
//   S_FILL | normal prefetch; responses are pushed into the queue
//   S_DROP | redirected with a request in flight; next response discarded

module instruction_fetch_queue #(
    parameter int                  I_WIDTH  = 32,
    parameter int                  A_WIDTH  = 32,
    parameter int                  PC_WIDTH = 32,
    parameter int                  DEPTH    = 4,
    parameter logic [PC_WIDTH-1:0] PC_STEP  = 4,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                   f_clk,
    input  logic                   f_rst,
    output logic                   o_syn,
    output logic [A_WIDTH-1:0]     o_addr_instr,
    input  logic                   i_ack,
    input  logic [I_WIDTH-1:0]     i_instr,
    input  logic                   change_pc,
    input  logic [PC_WIDTH-1:0]    alu_pc_value,
    input  logic                   i_stall,
    output logic                   o_ce,
    output logic [I_WIDTH-1:0]     o_instr,
    output logic [PC_WIDTH-1:0]    pc,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE = 1;
    localparam logic [CW-1:0] CNT_ONE = 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

    typedef enum logic {S_FILL, S_DROP} state_t;

    state_t              state;
    logic [PC_WIDTH-1:0] fpc;
    logic [PC_WIDTH-1:0] target;
    logic [PW-1:0]       rd_ptr;
    logic [PW-1:0]       wr_ptr;
    logic [CW-1:0]       count;
    logic [CW-1:0]       count_nxt;
    logic                syn_q;

    logic [PC_WIDTH-1:0] q_pc    [DEPTH];
    logic [I_WIDTH-1:0]  q_instr [DEPTH];

    logic not_empty;
    logic accept;
    logic byp_hit;
    logic byp_take;
    logic push;
    logic pop;

    assign not_empty = (count != '0);

    // A response is accepted only in FILL against a request actually on the bus.
    assign accept = (state == S_FILL) && syn_q && i_ack && !change_pc;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign byp_hit = accept && !not_empty;
`else
    assign byp_hit = 1'b0;
`endif

    // A bypassed response consumed by decode never enters the queue.
    assign byp_take = byp_hit && !i_stall;
    assign push     = accept && !byp_take;
    assign pop      = not_empty && !i_stall && !change_pc;

    always_comb begin
        count_nxt = count;
        if (change_pc) begin
            count_nxt = '0;
        end else if (push && !pop) begin
            count_nxt = count + CNT_ONE;
        end else if (pop && !push) begin
            count_nxt = count - CNT_ONE;
        end
    end

    // The request valid is registered from the next occupancy. It can only
    // fall on a push, and a push needs i_ack, so a raised request always
    // holds its address until acknowledged.
    always_ff @(posedge f_clk) begin
        if (f_rst) begin
            state  <= S_FILL;
            fpc    <= RESET_PC;
            target <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            syn_q  <= 1'b0;
        end else begin
            count <= count_nxt;
            syn_q <= (count_nxt < CNT_MAX);
            if (change_pc) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                if (syn_q && !i_ack) begin
                    // A request is still in flight; wait it out before redirecting.
                    state  <= S_DROP;
                    target <= alu_pc_value;
                end else begin
                    state <= S_FILL;
                    fpc   <= alu_pc_value;
                end
            end else begin
                case (state)
                    S_FILL: begin
                        if (accept) fpc <= fpc + PC_STEP;
                        if (push)   wr_ptr <= wr_ptr + PTR_ONE;
                        if (pop)    rd_ptr <= rd_ptr + PTR_ONE;
                    end
                    S_DROP: begin
                        if (i_ack) begin
                            fpc   <= target;
                            state <= S_FILL;
                        end
                    end
                    default: state <= S_FILL;
                endcase
            end
        end
    end

    always_ff @(posedge f_clk) begin
        if (push) begin
            q_pc[wr_ptr]    <= fpc;
            q_instr[wr_ptr] <= i_instr;
        end
    end

    always_comb begin
        o_ce    = not_empty || byp_hit;
        o_instr = '0;
        pc      = '0;
        if (not_empty) begin
            o_instr = q_instr[rd_ptr];
            pc      = q_pc[rd_ptr];
        end else if (byp_hit) begin
            o_instr = i_instr;
            pc      = fpc;
        end
    end

    assign o_syn        = syn_q;
    assign o_addr_instr = fpc[A_WIDTH-1:0];
    assign o_count      = count;

endmodule

// File: doc/instruction_fetch_queue.md
# instruction_fetch_queue

Parametrised successor to the single-slot fetch stage. It decouples instruction-memory handshakes from the decode stage with a DEPTH-entry prefetch queue. It issues sequential requests ahead of decode, tags each instruction with its PC, and flushes cleanly on a redirect. It sits between instruction memory and decode, with the same memory and redirect port set as the existing fetch stage.

## Interface
- I_WIDTH, 32, instruction width
- A_WIDTH, 32, memory address width (A_WIDTH <= PC_WIDTH; the address is the low A_WIDTH bits of the PC)
- PC_WIDTH, 32, PC width
- DEPTH, 4, queue entries; power of two, >= 2
- PC_STEP, 4, sequential PC increment
- RESET_PC, 0, first fetch address after reset
- f_clk  in  1  clock; all state updates on the rising edge
- f_rst  in  1  reset, synchronous, active-high
- o_syn  out  1  memory request valid
- o_addr_instr  out  A_WIDTH  request address
- i_ack  in  1  memory response; completes the pending request at this edge
- i_instr  in  I_WIDTH  instruction data, valid when i_ack=1
- change_pc  in  1  redirect/flush
- alu_pc_value  in  PC_WIDTH  redirect target
- i_stall  in  1  decode not accepting
- o_ce  out  1  head entry valid to decode
- o_instr  out  I_WIDTH  head instruction
- pc  out  PC_WIDTH  PC of the head instruction
- o_count  out  $clog2(DEPTH)+1  queue occupancy

## Operation
- State: fetch PC `fpc`, circular queue of {pc, instr} with read/write pointers and counter, FSM {FILL, DROP}, and a DROP-target register.
- FILL: `o_syn` = (count < DEPTH); `o_addr_instr` = `fpc`.
- On `i_ack` & `o_syn` (no redirect): push {`fpc`, `i_instr`}, then `fpc` += PC_STEP, modulo 2^PC_WIDTH.
- `i_ack` while `o_syn`=0 is ignored.
- Handshake rule: once `o_syn` rises, `o_syn` and `o_addr_instr` hold until `i_ack`. Count only increases by a push, so this holds by construction.
- Pop on `o_ce` & !`i_stall`. Push and pop in the same edge leave count unchanged. A push into a full queue cannot occur.
- `o_ce` = (count != 0). When `o_ce`=0, `o_instr` and `pc` are driven to 0.
- `change_pc`:
  - Same edge: queue emptied, pop suppressed.
  - If `o_syn`=1 and `i_ack`=0: go to DROP, target := `alu_pc_value`.
  - Otherwise: `fpc` := `alu_pc_value`, stay in FILL; a simultaneous `i_ack` is discarded.
- DROP:
  - `o_syn`=1 with the old address held.
  - On `i_ack`: data discarded, `fpc` := target, go to FILL.
  - `change_pc` in DROP updates the target and stays in DROP.
  - Queue stays empty.
- Priority: `f_rst` > `change_pc` > push/pop.

## Timing
- Reset values: `o_syn`=0, `o_addr_instr`=RESET_PC[A_WIDTH-1:0], `o_ce`=0, `o_instr`=0, `pc`=0, `o_count`=0, FSM=FILL. Reset mid-request abandons it; memory must tolerate this.
- First request: `o_syn`=1 in the first cycle after `f_rst` deasserts.
- Ack-to-decode latency: 1 cycle. With `i_ack` at edge N, `o_ce`=1 after edge N.
- Throughput: with `i_ack` held high and `i_stall`=0, one instruction per cycle, and addresses advance by PC_STEP each cycle.
- Redirect: `o_ce`=0 in the cycle after `change_pc`. The first new-target request appears in that same cycle, or in the cycle after the dropping `i_ack`.

## Configuration
- `FETCH_QUEUE_BYPASS_EN` defined:
  - When the queue is empty in FILL and `i_ack`=1 (no `change_pc`), the ack data and `fpc` drive `o_instr`/`pc` combinationally, with `o_ce`=1 in the ack cycle.
  - If `i_stall`=0, the entry is consumed and not written; otherwise it is written normally.
  - Latency becomes 0.
- Not defined: no combinational path from `i_ack`/`i_instr` to the outputs; latency is 1.

## Test plan
- Reset, then `i_ack`=1 for 3 cycles with A0A0A0A0, B1B1B1B1, C2C2C2C2, `i_stall`=0 -> addresses 0, 4, 8 back-to-back; decode sees the same three instructions with `pc`=0, 4, 8 on consecutive cycles.
- `i_stall`=1, DEPTH=4, acks continuing -> `o_count` reaches 4, `o_syn` drops, addresses stop at 0x10. Releasing the stall drains in order and `o_syn` reasserts at 0x10.
- `change_pc`=1, `alu_pc_value`=0x100 with `i_ack`=1 in the same cycle -> that data is discarded, `o_count`=0, next request is 0x100.
- `change_pc` to 0x200 while request 0x8 is pending (`i_ack`=0) -> DROP holds `o_syn` at 0x8. `i_ack`=1 with D3D3D3D3 is discarded, then the request is at 0x200 and decode sees only data from 0x200.
- Assert `f_rst` mid-request with 2 entries queued -> all outputs at their reset values the next cycle, and the first request afterwards is RESET_PC.
- `FETCH_QUEUE_BYPASS_EN` defined, empty queue, `i_ack`=1 with E4E4E4E4 at `fpc`=0x104 -> `o_ce`=1, `o_instr`=E4E4E4E4, `pc`=0x104 in the same cycle; `o_count` stays 0 when `i_stall`=0.
